// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped write-through, no-write-allocate cache controller.
// Optional hit/miss counters are built only when CACHE_STATS_EN is defined.
module cache_ctrl #(
  parameter int TAG_LEN    = 4,
  parameter int INDEX_LEN  = 2,
  parameter int OFFSET_LEN = 2,
  parameter int WORD_S     = 32
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      cpu_req,
  input  logic                                      cpu_write,
  input  logic [TAG_LEN+INDEX_LEN+OFFSET_LEN-1:0]   cpu_addr,
  input  logic [WORD_S-1:0]                         cpu_wdata,
  output logic [WORD_S-1:0]                         cpu_rdata,
  output logic                                      cpu_ready,
  output logic                                      mem_req,
  output logic                                      mem_write,
  output logic [TAG_LEN+INDEX_LEN+OFFSET_LEN-1:0]   mem_addr,
  output logic [WORD_S-1:0]                         mem_wdata,
  input  logic [WORD_S*(2**OFFSET_LEN)-1:0]         mem_rdata,
  input  logic                                      mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                               hit_count,
  output logic [31:0]                               miss_count
`endif
);

  localparam int LINES  = 2**INDEX_LEN;
  localparam int ADDR_W = TAG_LEN + INDEX_LEN + OFFSET_LEN;
  localparam int LINE_W = WORD_S * (2**OFFSET_LEN);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [WORD_S-1:0]     wdata_q;
  logic [WORD_S-1:0]     rdata_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_LEN-1:0]    tag_arr_q  [LINES];
  logic [LINE_W-1:0]     data_arr_q [LINES];

  logic [TAG_LEN-1:0]    in_tag, q_tag;
  logic [INDEX_LEN-1:0]  in_idx, q_idx;
  logic [OFFSET_LEN-1:0] in_off, q_off;
  logic                  in_hit, q_hit, accept;

  assign in_tag = cpu_addr[ADDR_W-1 -: TAG_LEN];
  assign in_idx = cpu_addr[OFFSET_LEN +: INDEX_LEN];
  assign in_off = cpu_addr[OFFSET_LEN-1:0];
  assign q_tag  = addr_q[ADDR_W-1 -: TAG_LEN];
  assign q_idx  = addr_q[OFFSET_LEN +: INDEX_LEN];
  assign q_off  = addr_q[OFFSET_LEN-1:0];

  assign in_hit = valid_q[in_idx] && (tag_arr_q[in_idx] == in_tag);
  assign q_hit  = valid_q[q_idx] && (tag_arr_q[q_idx] == q_tag);
  assign accept = (state_q == IDLE) && cpu_req;

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_write)   state_d = WRITE;
          else if (in_hit) state_d = RESP;
          else             state_d = FILL;
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {q_tag, q_idx, {OFFSET_LEN{1'b0}}};
        if (mem_ack) state_d = RESP;
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ack) state_d = RESP;
      end
      RESP: begin
        cpu_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_rdata = rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        if (!cpu_write && in_hit)
          rdata_q <= data_arr_q[in_idx][in_off*WORD_S +: WORD_S];
      end
      if ((state_q == FILL) && mem_ack) begin
        valid_q[q_idx] <= 1'b1;
        rdata_q        <= mem_rdata[q_off*WORD_S +: WORD_S];
      end
    end
  end

  // Arrays carry no reset; state_q is forced to IDLE by reset, which blocks any update.
  always_ff @(posedge clk) begin
    if ((state_q == FILL) && mem_ack) begin
      tag_arr_q[q_idx]  <= q_tag;
      data_arr_q[q_idx] <= mem_rdata;
    end else if ((state_q == WRITE) && mem_ack && q_hit) begin
      data_arr_q[q_idx][q_off*WORD_S +: WORD_S] <= wdata_q;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept && !cpu_write) begin
      if (in_hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - directed bench for cache_ctrl with a line-level cache and memory model.
module tb_cache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req, cpu_write;
  logic [5:0]   cpu_addr;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         cpu_ready, mem_req, mem_write;
  logic [5:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  cache_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [64];
  logic        m_valid [4];
  logic [31:0] m_tag   [4];
  logic [31:0] m_data  [4][4];

  logic        exp_mem_req, exp_mem_write, exp_ready;
  logic [31:0] exp_mem_addr, exp_mem_wdata, exp_rdata;
  logic [31:0] seen_addr;
  int          req_cycles;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endfunction

  // Per-cycle comparison against the model's expectations.
  always @(negedge clk) begin
    chk("mem_req", {31'd0, mem_req}, {31'd0, exp_mem_req});
    chk("cpu_ready", {31'd0, cpu_ready}, {31'd0, exp_ready});
    chk("cpu_rdata", cpu_rdata, exp_rdata);
    if (exp_mem_req) begin
      chk("mem_write", {31'd0, mem_write}, {31'd0, exp_mem_write});
      chk("mem_addr", {26'd0, mem_addr}, exp_mem_addr);
      if (exp_mem_write) chk("mem_wdata", mem_wdata, exp_mem_wdata);
    end
    if (mem_req) begin
      seen_addr = {26'd0, mem_addr};
      req_cycles++;
    end
  end

  task automatic txn(input bit wr, input int addr, input logic [31:0] wd, input int dly);
    int idx, tg, off, base;
    bit hit;
    idx  = (addr / 4) % 4;
    tg   = addr / 16;
    off  = addr % 4;
    base = addr - off;
    hit  = m_valid[idx] && (m_tag[idx] == tg);
    cpu_req = 1'b1; cpu_write = wr; cpu_addr = 6'(addr); cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    if (!wr && hit) begin
      exp_ready = 1'b1;
      exp_rdata = m_data[idx][off];
    end else begin
      exp_mem_req   = 1'b1;
      exp_mem_write = wr;
      exp_mem_addr  = wr ? addr : base;
      exp_mem_wdata = wd;
      for (int i = 0; i < dly; i++) begin
        // Requests while busy must be ignored.
        cpu_req = 1'b1; cpu_write = ~wr; cpu_addr = 6'(addr) ^ 6'h3F;
        @(posedge clk); #1;
      end
      cpu_req = 1'b0;
      mem_ack = 1'b1;
      if (!wr)
        for (int w = 0; w < 4; w++) mem_rdata[w*32 +: 32] = mem_model[base + w];
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (wr) begin
        mem_model[addr] = wd;
        if (hit) m_data[idx][off] = wd;
      end else begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        for (int w = 0; w < 4; w++) m_data[idx][w] = mem_model[base + w];
        exp_rdata = mem_model[addr];
      end
      exp_mem_req = 1'b0;
      exp_ready   = 1'b1;
    end
    @(posedge clk); #1;
    exp_ready = 1'b0;
  endtask

  int rc0;

  initial begin
    for (int a = 0; a < 64; a++) mem_model[a] = 32'hC0DE_0000 + a;
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    reset = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    exp_mem_req = 1'b0; exp_mem_write = 1'b0; exp_ready = 1'b0;
    exp_mem_addr = '0; exp_mem_wdata = '0; exp_rdata = '0;
    seen_addr = '0; req_cycles = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_mem_addr", {26'd0, mem_addr}, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    txn(0, 6'h00, 0, 3);
    chk("lit_r00_data", cpu_rdata, 32'hC0DE_0000);
    chk("lit_r00_addr", seen_addr, 32'h00);
    rc0 = req_cycles;
    txn(0, 6'h01, 0, 0);
    chk("lit_r01_data", cpu_rdata, 32'hC0DE_0001);
    chk("lit_r01_nomem", req_cycles, rc0);
`ifdef CACHE_STATS_EN
    chk("lit_hit_count", hit_count, 32'd1);
    chk("lit_miss_count", miss_count, 32'd1);
`endif

    txn(1, 6'h01, 32'hDEAD_BEEF, 1);
    chk("lit_w01_addr", seen_addr, 32'h01);
    rc0 = req_cycles;
    txn(0, 6'h01, 0, 0);
    chk("lit_r01_new", cpu_rdata, 32'hDEAD_BEEF);
    chk("lit_r01_new_nomem", req_cycles, rc0);

    txn(1, 6'h25, 32'h1234_5678, 0);
    txn(0, 6'h25, 0, 2);
    chk("lit_r25_addr", seen_addr, 32'h24);
    chk("lit_r25_data", cpu_rdata, 32'h1234_5678);

    txn(0, 6'h00, 0, 0);
    txn(0, 6'h10, 0, 1);
    chk("lit_r10_addr", seen_addr, 32'h10);
    rc0 = req_cycles;
    txn(0, 6'h00, 0, 1);
    chk("lit_r00_refill", (req_cycles > rc0) ? 32'd1 : 32'd0, 32'd1);

    txn(1, 6'h30, 32'hAAAA_5555, 0);
    txn(0, 6'h00, 0, 0);
    chk("lit_r00_untouched", cpu_rdata, 32'hC0DE_0000);

    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;

    // Abort a fill with reset two cycles in.
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 6'h10;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    exp_mem_req = 1'b1; exp_mem_write = 1'b0; exp_mem_addr = 32'h10;
    @(posedge clk); #1;
    #2;
    reset = 1'b1;
    exp_mem_req = 1'b0; exp_ready = 1'b0; exp_rdata = '0;
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    #1;
    chk("lit_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("lit_rst_mem_addr", {26'd0, mem_addr}, 32'd0);
    chk("lit_rst_cpu_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;

    rc0 = req_cycles;
    txn(0, 6'h00, 0, 2);
    chk("lit_post_rst_miss", (req_cycles > rc0) ? 32'd1 : 32'd0, 32'd1);
    chk("lit_post_rst_data", cpu_rdata, 32'hC0DE_0000);

    txn(0, 6'h3F, 0, 1);
    chk("lit_r3f_addr", seen_addr, 32'h3C);
    chk("lit_r3f_data", cpu_rdata, 32'hC0DE_003F);
    txn(0, 6'h3C, 0, 0);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 The block SHALL have parameter TAG_LEN, default 4, meaning tag width in bits.
REQ-002 The block SHALL have parameter INDEX_LEN, default 2, meaning index width; line count = 2**INDEX_LEN.
REQ-003 The block SHALL have parameter OFFSET_LEN, default 2, meaning word-offset width; words per line = 2**OFFSET_LEN.
REQ-004 The block SHALL have parameter WORD_S, default 32, meaning word width; line width LINE_W = WORD_S*2**OFFSET_LEN; ADDR_W = TAG_LEN+INDEX_LEN+OFFSET_LEN (word address).
REQ-005 The block SHALL have one clock, clk; reset is asynchronous and active-high.
REQ-006 The block SHALL have these ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
cpu_req  in  1  request, sampled only in IDLE
cpu_write  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  word address {tag,index,offset}
cpu_wdata  in  WORD_S  write data
cpu_rdata  out  WORD_S  read data, valid with cpu_ready on reads
cpu_ready  out  1  one-cycle completion pulse
mem_req  out  1  memory request, held until mem_ack
mem_write  out  1  1=word write, 0=line read
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  WORD_S  memory write data
mem_rdata  in  LINE_W  fill line, word 0 in LSBs, valid with mem_ack
mem_ack  in  1  memory completion, one cycle

Function
REQ-007 The block SHALL implement a direct-mapped, write-through, no-write-allocate cache with per-line valid bit, tag array and data array.
REQ-008 The FSM SHALL have states IDLE, FILL, WRITE, RESP; reset state IDLE.
REQ-009 In IDLE with cpu_req=1, the block SHALL register cpu_write/addr/wdata and go to RESP on read hit, FILL on read miss, WRITE on any write.
REQ-010 A read hit accepted in cycle N SHALL give cpu_ready=1 with cpu_rdata=addressed word in cycle N+1, with no mem_req.
REQ-011 In FILL, mem_req=1, mem_write=0, mem_addr={tag,index,0}; in the mem_ack cycle the line, tag and valid=1 SHALL be stored and the addressed word latched; next state RESP.
REQ-012 In WRITE, mem_req=1, mem_write=1, mem_addr=registered address, mem_wdata=registered data; on mem_ack, if line valid and tag matches, the word SHALL be updated in place, else the array is unchanged; next state RESP.
REQ-013 RESP SHALL assert cpu_ready for exactly one cycle, then go to IDLE; a new request MAY be accepted in the following cycle.
REQ-014 mem_addr, mem_write and mem_wdata SHALL remain stable while mem_req=1; mem_ack outside FILL/WRITE SHALL be ignored.
REQ-015 cpu_req outside IDLE SHALL be ignored; cpu_rdata SHALL change only on read completion and hold otherwise.
REQ-016 A fill to an occupied index SHALL replace the line with no write-back.

Reset
REQ-017 Asserting reset SHALL immediately force IDLE, clear all valid bits and drive cpu_ready, cpu_rdata, mem_req, mem_write, mem_addr, mem_wdata to 0; data and tag arrays are not reset.
REQ-018 Reset during FILL or WRITE SHALL abandon the transaction with no array update and no cpu_ready.

Configuration
REQ-019 With CACHE_STATS_EN defined, the block SHALL add outputs hit_count and miss_count (32 bits, saturating, reset 0), incremented on accepted reads by hit/miss; without it, these ports and counters SHALL not exist.

Verification (TAG_LEN=4, INDEX_LEN=2, OFFSET_LEN=2, WORD_S=32)
REQ-020 Reset, read 0x00 -> mem_req, mem_addr=0x00; ack after 3 cycles with mem_rdata={D3,D2,D1,D0} -> cpu_ready, cpu_rdata=D0; read 0x01 -> cpu_ready next cycle, cpu_rdata=D1, no mem_req.
REQ-021 After REQ-020, write 0x01=0xDEADBEEF -> mem_write=1, mem_addr=0x01; after ack, read 0x01 -> 0xDEADBEEF with no mem_req.
REQ-022 Write 0x25=0x12345678 to invalid index 1 -> memory write only; subsequent read 0x25 -> miss, mem_addr=0x24.
REQ-023 Read 0x00 (filled), read 0x10 -> miss replaces index 0; read 0x00 again -> miss.
REQ-024 Reset asserted two cycles into FILL -> mem_req=0 immediately, no cpu_ready; read 0x00 afterwards -> miss.
REQ-025 With CACHE_STATS_EN, after REQ-020 -> hit_count=1, miss_count=1; without it, module elaborates with no counter ports.
